prog_counter: RTL and testbench
===============================

Name: prog_counter

Overview:
- Parametrised successor to the lab 6-bit load-and-count-down counter.
- Adds configurable width, a clock prescaler, up/down direction, one-shot or auto-reload mode, a pause input, and busy/done status.
- Sits between control logic (load and configuration) and consumers of the terminal-count pulse `oflag`, such as periodic event generation or delays.

Parameters:
- WIDTH, 6: bit width of `din` and `count`.
- PRESC_W, 4: bit width of the `presc` prescaler divide field.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rstn  in  1  asynchronous active-low reset.
- din  in  WIDTH  run length N; latched on load.
- ena  in  1  load/start strobe; sampled every rising edge.
- dir  in  1  0 = count down from N to 0; 1 = count up from 0 to N. Latched on load.
- mode  in  1  0 = one-shot; 1 = auto-reload. Latched on load.
- presc  in  PRESC_W  count advances once per (presc+1) clocks. Latched on load.
- pause  in  1  freezes counting while high.
- count  out  WIDTH  current count value.
- busy  out  1  high while in RUN or HOLD.
- oflag  out  1  one-cycle pulse on each terminal count.
- done  out  1  sticky one-shot completion; cleared by the next load.

Behaviour:
- Reset (rstn=0, asynchronous): state=IDLE, count=0, busy=0, oflag=0, done=0, prescaler=0, all latched config=0. Release is synchronous to the next clk edge.
- FSM states: IDLE, RUN, HOLD. `busy` = (state != IDLE), registered with the state.
- Load (ena=1 at edge k):
  - Highest priority; wins over `pause` and over any in-progress run, from any state.
  - Latches din→N, dir, mode, presc.
  - Clears the prescaler and `done`.
  - Sets count = N (dir=0) or 0 (dir=1).
  - state=RUN after edge k.
  - An aborted run produces no `oflag`.
- Load with din=0: count=0, state=IDLE, oflag=1 in the cycle after edge k. `done` = 1 if mode=0, else stays 0.
- Tick:
  - In RUN, the prescaler increments each edge.
  - A tick occurs on the edge where prescaler == presc; the prescaler then wraps to 0.
  - presc=0 gives a tick every clock.
- Step on tick:
  - dir=0: count decrements.
  - dir=1: count increments.
  - First step lands on edge k+presc+1.
- Terminal step: a tick with count==1 (dir=0) or count==N-1 (dir=1).
  - oflag=1 for exactly the cycle following the terminal edge.
  - One-shot: count takes the terminal value (0 or N) and holds it; state→IDLE; done=1 (same cycle as oflag).
  - Auto-reload: count reloads to N (dir=0) or 0 (dir=1); state stays RUN. Period = N ticks = N·(presc+1) clocks.
- Pause:
  - RUN with pause=1 → HOLD.
  - HOLD with pause=0 → RUN.
  - In HOLD, count and prescaler are frozen and no tick occurs.
  - Pause has no effect in IDLE.
- Config changes: changes to din/dir/mode/presc outside a load edge are ignored.
- Widths:
  - count never wraps modulo 2^WIDTH; the terminal check prevents underflow and overflow.
  - N = 2^WIDTH−1 is legal.
- Outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
1. WIDTH=6, reset then din=8, dir=0, mode=0, presc=0, ena pulse for 1 cycle -> count 8,7,…,0 on successive edges. oflag is high for one cycle when count first reads 0; done=1; busy=0; count holds at 0.
2. din=4, dir=1, mode=1, presc=2 -> count steps every 3 clocks: 0,1,2,3,0,1… oflag pulses every 12 clocks; done stays 0; busy stays 1.
3. din=16, dir=0, presc=0; pause high for 5 cycles at count=10 -> count holds 10 for 5 cycles, then resumes. oflag arrives 5 cycles later than in the unpaused run.
4. Mid-run reload: din=16 running, at count=9 apply ena with din=3 -> count=3, then 2,1,0. Exactly one oflag (for the second run); ena asserted together with pause=1 still loads.
5. Edge values: din=0 load -> oflag 1 cycle and busy never rises. din=63, dir=1 -> count reaches 63 with no wrap.
6. Assert rstn low mid-run (count=5, presc=3) -> all outputs 0 immediately, without waiting for a clk edge. After release, the counter stays IDLE until the next ena.

Source files
------------

// File: rtl/prog_counter.sv
// Programmable load-and-count timer: width, prescaler, direction, one-shot or
// auto-reload, pause, and busy/done status. Terminal count pulses oflag.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | no run in progress; count holds its last value
// S_RUN  | counting; prescaler advances each clock
// S_HOLD | run paused; count and prescaler frozen until pause drops
module prog_counter #(
    parameter int WIDTH   = 6,
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [WIDTH-1:0]   din,
    input  logic               ena,
    input  logic               dir,
    input  logic               mode,
    input  logic [PRESC_W-1:0] presc,
    input  logic               pause,
    output logic [WIDTH-1:0]   count,
    output logic               busy,
    output logic               oflag,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   n_q;
    logic               dir_q;
    logic               mode_q;
    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] pre_cnt;

    logic at_terminal;

    // Comparing against the terminal-minus-one value keeps count inside [0, N].
    assign at_terminal = dir_q ? (count == n_q - WIDTH'(1)) : (count == WIDTH'(1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= S_IDLE;
            count   <= '0;
            busy    <= 1'b0;
            oflag   <= 1'b0;
            done    <= 1'b0;
            n_q     <= '0;
            dir_q   <= 1'b0;
            mode_q  <= 1'b0;
            presc_q <= '0;
            pre_cnt <= '0;
        end else begin
            oflag <= 1'b0;
            if (ena) begin
                n_q     <= din;
                dir_q   <= dir;
                mode_q  <= mode;
                presc_q <= presc;
                pre_cnt <= '0;
                done    <= 1'b0;
                if (din == '0) begin
                    // Zero-length run terminates immediately.
                    count <= '0;
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    oflag <= 1'b1;
                    done  <= ~mode;
                end else begin
                    count <= dir ? '0 : din;
                    state <= S_RUN;
                    busy  <= 1'b1;
                end
            end else begin
                case (state)
                    S_RUN, S_HOLD: begin
                        if (pause) begin
                            state <= S_HOLD;
                        end else begin
                            state <= S_RUN;
                            if (pre_cnt == presc_q) begin
                                pre_cnt <= '0;
                                if (at_terminal) begin
                                    oflag <= 1'b1;
                                    if (mode_q) begin
                                        count <= dir_q ? '0 : n_q;
                                    end else begin
                                        count <= dir_q ? n_q : '0;
                                        state <= S_IDLE;
                                        busy  <= 1'b0;
                                        done  <= 1'b1;
                                    end
                                end else begin
                                    count <= dir_q ? count + WIDTH'(1) : count - WIDTH'(1);
                                end
                            end else begin
                                pre_cnt <= pre_cnt + PRESC_W'(1);
                            end
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_counter.sv
// Bench for prog_counter: directed scenarios plus random stimulus, every cycle
// compared against a tick-counting reference model.
module tb_prog_counter;

    localparam int WIDTH   = 6;
    localparam int PRESC_W = 4;
    localparam int NMAX    = (1 << WIDTH) - 1;

    logic               clk;
    logic               rstn;
    logic [WIDTH-1:0]   din;
    logic               ena;
    logic               dir;
    logic               mode;
    logic [PRESC_W-1:0] presc;
    logic               pause;
    logic [WIDTH-1:0]   count;
    logic               busy;
    logic               oflag;
    logic               done;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a run is "steps completed out of N", plus clocks since last step.
    bit m_active;
    int m_n, m_presc, m_steps, m_sub;
    bit m_dir, m_mode, m_flag, m_done;
    int flag_seen;

    prog_counter #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .din   (din),
        .ena   (ena),
        .dir   (dir),
        .mode  (mode),
        .presc (presc),
        .pause (pause),
        .count (count),
        .busy  (busy),
        .oflag (oflag),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int exp_count();
        return m_dir ? m_steps : m_n - m_steps;
    endfunction

    task automatic model_reset();
        m_active = 0; m_n = 0; m_presc = 0; m_steps = 0; m_sub = 0;
        m_dir = 0; m_mode = 0; m_flag = 0; m_done = 0;
    endtask

    task automatic model_step();
        m_flag = 0;
        if (ena) begin
            m_n = int'(din); m_dir = dir; m_mode = mode; m_presc = int'(presc);
            m_sub = 0; m_steps = 0; m_done = 0;
            if (m_n == 0) begin
                m_active = 0;
                m_flag   = 1;
                m_done   = !mode;
            end else begin
                m_active = 1;
            end
        end else if (m_active && !pause) begin
            if (m_sub == m_presc) begin
                m_sub = 0;
                m_steps++;
                if (m_steps == m_n) begin
                    m_flag = 1;
                    if (m_mode) m_steps = 0;
                    else begin
                        m_active = 0;
                        m_done   = 1;
                    end
                end
            end else begin
                m_sub++;
            end
        end
    endtask

    task automatic compare_all();
        chk("count", 32'(count), 32'(exp_count()));
        chk("busy",  32'(busy),  32'(m_active));
        chk("oflag", 32'(oflag), 32'(m_flag));
        chk("done",  32'(done),  32'(m_done));
        if (oflag) flag_seen++;
    endtask

    task automatic cycle(input bit e, input int d, input bit dr, input bit md,
                         input int p, input bit ps);
        ena = e; din = WIDTH'(d); dir = dr; mode = md; presc = PRESC_W'(p); pause = ps;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle_cycles(input int n, input bit ps);
        for (int i = 0; i < n; i++) cycle(0, $urandom_range(0, NMAX), $urandom_range(0, 1),
                                           $urandom_range(0, 1), $urandom_range(0, 15), ps);
    endtask

    initial begin
        rstn = 1'b0; ena = 0; din = '0; dir = 0; mode = 0; presc = '0; pause = 0;
        model_reset();
        flag_seen = 0;
        #12;
        compare_all();
        @(negedge clk);
        rstn = 1'b1;

        // One-shot down from 8.
        cycle(1, 8, 0, 0, 0, 0);
        idle_cycles(12, 0);
        chk("oneshot_flags", 32'(flag_seen), 32'd1);

        // Auto-reload up, N=4, presc=2: expect oflag every 12 clocks.
        flag_seen = 0;
        cycle(1, 4, 1, 1, 2, 0);
        idle_cycles(48, 0);
        chk("reload_flags", 32'(flag_seen), 32'd4);

        // Pause for 5 cycles at count=10.
        cycle(1, 16, 0, 0, 0, 0);
        idle_cycles(6, 0);
        chk("pause_at", 32'(count), 32'd10);
        idle_cycles(5, 1);
        chk("pause_hold", 32'(count), 32'd10);
        idle_cycles(14, 0);

        // Mid-run reload while paused: aborted run gives no oflag.
        flag_seen = 0;
        cycle(1, 16, 0, 0, 0, 0);
        idle_cycles(7, 0);
        cycle(1, 3, 0, 0, 0, 1);
        chk("reload_val", 32'(count), 32'd3);
        idle_cycles(6, 0);
        chk("reload_flags2", 32'(flag_seen), 32'd1);

        // Edge values: zero-length load and full-range up count.
        cycle(1, 0, 0, 0, 5, 0);
        idle_cycles(3, 0);
        cycle(1, 0, 1, 1, 0, 0);
        idle_cycles(3, 0);
        cycle(1, NMAX, 1, 0, 0, 0);
        idle_cycles(NMAX + 4, 0);
        chk("max_count", 32'(count), 32'(NMAX));

        // Asynchronous reset mid-run.
        cycle(1, 16, 0, 1, 3, 0);
        idle_cycles(45, 0);
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rstn = 1'b1;
        idle_cycles(10, 0);

        // Random stimulus.
        for (int i = 0; i < 4000; i++) begin
            int r, d, p;
            bit e;
            e = ($urandom_range(0, 39) == 0);
            r = $urandom_range(0, 9);
            d = (r == 0) ? 0 : (r == 1) ? NMAX : (r == 2) ? 1 : $urandom_range(2, 12);
            p = (d == NMAX) ? 0 : $urandom_range(0, 3);
            if (!e) begin
                d = $urandom_range(0, NMAX);
                p = $urandom_range(0, 15);
            end
            cycle(e, d, $urandom_range(0, 1), $urandom_range(0, 1), p, $urandom_range(0, 7) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
